// File: rtl/tnoc_pkg.sv
// Shared NoC configuration type and the default configuration used by the router blocks.
package tnoc_pkg;

    typedef struct packed {
        int virtual_channels;
        int data_width;
    } tnoc_config;

    localparam tnoc_config TNOC_DEFAULT_CONFIG = '{virtual_channels: 2, data_width: 32};

endpackage

// File: rtl/tnoc_port_arbiter.sv
// Output-port arbiter: per-VC round-robin choice among packet heads, grant held
// (wormhole lock) until the granted requester frees its tail flit.
module tnoc_port_arbiter
    import tnoc_pkg::*;
#(
    parameter tnoc_config CONFIG   = TNOC_DEFAULT_CONFIG,
    parameter int         ENTRIES  = 5,
    localparam int        CHANNELS = CONFIG.virtual_channels
)(
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [ENTRIES*CHANNELS-1:0]  i_request,
    output logic [ENTRIES*CHANNELS-1:0]  o_grant,
    input  logic [ENTRIES*CHANNELS-1:0]  i_free,
    input  logic [ENTRIES*CHANNELS-1:0]  i_start_of_packet,
    input  logic [ENTRIES*CHANNELS-1:0]  i_end_of_packet,
    output logic [CHANNELS-1:0]          o_vc_busy
);

    localparam int PTR_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    for (genvar v = 0; v < CHANNELS; v++) begin : g_vc
        state_e             r_state;
        state_e             w_state_next;
        logic [ENTRIES-1:0] r_grant;
        logic [ENTRIES-1:0] w_grant_next;
        logic [ENTRIES-1:0] w_cand;
        logic [ENTRIES-1:0] w_tail;
        logic [PTR_W-1:0]   r_ptr;
        logic [PTR_W-1:0]   w_ptr_next;
        logic [PTR_W-1:0]   w_winner;
        logic               w_found;
        logic               w_release;

        for (genvar e = 0; e < ENTRIES; e++) begin : g_ent
            assign w_cand[e] = i_request[e*CHANNELS+v] & i_start_of_packet[e*CHANNELS+v];
            assign w_tail[e] = i_free[e*CHANNELS+v] & i_end_of_packet[e*CHANNELS+v];
            assign o_grant[e*CHANNELS+v] = r_grant[e];
        end

        // Only the holder's tail can unlock the VC; other requesters' free/eop are masked.
        assign w_release = |(r_grant & w_tail);

        // Walk offsets from the highest down so the candidate nearest the pointer wins.
        always_comb begin
            logic [PTR_W:0] w_sum;
            w_found  = 1'b0;
            w_winner = '0;
            w_sum    = '0;
            for (int k = ENTRIES - 1; k >= 0; k--) begin
                w_sum = {1'b0, r_ptr} + (PTR_W+1)'(k);
                if (w_sum >= (PTR_W+1)'(ENTRIES)) begin
                    w_sum = w_sum - (PTR_W+1)'(ENTRIES);
                end
                if (w_cand[w_sum[PTR_W-1:0]]) begin
                    w_found  = 1'b1;
                    w_winner = w_sum[PTR_W-1:0];
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state <= IDLE;
                r_grant <= '0;
                r_ptr   <= '0;
            end else begin
                r_state <= w_state_next;
                r_grant <= w_grant_next;
                r_ptr   <= w_ptr_next;
            end
        end

        always_comb begin
            w_state_next = r_state;
            case (r_state)
                IDLE:    if (w_found)   w_state_next = BUSY;
                BUSY:    if (w_release) w_state_next = IDLE;
                default: w_state_next = IDLE;
            endcase
        end

        always_comb begin
            w_grant_next = r_grant;
            w_ptr_next   = r_ptr;
            case (r_state)
                IDLE: begin
                    w_grant_next = '0;
                    if (w_found) begin
                        w_grant_next[w_winner] = 1'b1;
                        w_ptr_next = (w_winner == PTR_W'(ENTRIES - 1)) ? '0 : w_winner + 1'b1;
                    end
                end
                BUSY: begin
                    if (w_release) w_grant_next = '0;
                end
                default: w_grant_next = '0;
            endcase
        end

        assign o_vc_busy[v] = (r_state == BUSY);
    end

endmodule
